// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and constants for the pipeline hazard
//                controller: FSM state encoding, the hard-wired zero
//                register index, the multiply/divide down-counter width and a
//                helper that detects a source/destination register match.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Two-state controller: normal issue, or held while mul/div occupies EX.
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    // Register 0 is hard-wired to zero, so writes to it never create a hazard.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Wide enough for the largest legal MD_LAT-2 reload value (13).
    localparam int MD_CNT_W = 4;

    // True when the ID instruction actually reads a source equal to dst.
    function automatic logic reg_match(input logic       uses,
                                       input logic [4:0] src,
                                       input logic [4:0] dst);
        return uses && (src == dst);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that increments by one per enabled cycle and
//                holds at all-ones instead of wrapping.
//  Ports       : clk   - clock, rising edge
//                rst   - asynchronous active-high reset, clears the count
//                inc   - increment request for this cycle
//                count - current count value
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller. Detects load-use hazards,
//                flushes IF/ID on taken branches and, when built with the
//                HAZARD_MULDIV_EN macro, holds the front end while a
//                multi-cycle multiply/divide occupies EX. Keeps saturating
//                counts of stall cycles and branch flushes.
//  Config      : `define HAZARD_MULDIV_EN to build the MD_BUSY state and its
//                down-counter; otherwise id_md_start is ignored and md_busy
//                is tied low (all ports remain).
//  Ports       : clk, rst          - clock / asynchronous active-high reset
//                id_rs, id_rt      - source fields of the ID instruction
//                id_uses_rs/rt     - ID instruction reads Rs / Rt
//                id_md_start       - ID instruction is a multiply/divide
//                ex_mem_read       - ID/EX holds a load
//                ex_rt             - destination of the ID/EX instruction
//                ex_branch_taken   - branch resolved taken in EX
//                pc_write          - PC update enable
//                ifid_write        - IF/ID load enable
//                ifid_flush        - clear IF/ID to NOP
//                idex_bubble       - zero control fields entering ID/EX
//                md_busy           - multiply/divide unit occupied
//                stall_cnt         - saturating stall-cycle count
//                flush_cnt         - saturating taken-branch flush count
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_md_start,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic w_load_use;
    logic w_busy;
    logic w_stall_inc;
    logic w_flush_inc;

    // A load targeting register 0 never produces a value worth waiting for.
    always_comb begin
        w_load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                     (reg_match(id_uses_rs, id_rs, ex_rt) ||
                      reg_match(id_uses_rt, id_rt, ex_rt));
    end

`ifdef HAZARD_MULDIV_EN
    // The start cycle itself flows normally, so the busy window is MD_LAT-1
    // cycles: reload with MD_LAT-2 and leave when the counter reads zero.
    localparam logic [MD_CNT_W-1:0] MD_RELOAD = MD_CNT_W'(MD_LAT - 2);

    state_e              state_q;
    state_e              state_d;
    logic [MD_CNT_W-1:0] md_cnt_q;
    logic [MD_CNT_W-1:0] md_cnt_d;

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            RUN: begin
                // Branch and load-use both outrank a new mul/div issue.
                if (!ex_branch_taken && !w_load_use && id_md_start) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = MD_RELOAD;
                end
            end
            MD_BUSY: begin
                if (md_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    md_cnt_d = md_cnt_q - {{(MD_CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d  = RUN;
                md_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    assign w_busy = (state_q == MD_BUSY);
`else
    // Mul/div support not built: keep the port, discard its value.
    logic unused_md_cfg;
    assign unused_md_cfg = id_md_start ^ MD_LAT[0];
    assign w_busy        = 1'b0;
`endif

    // Outputs are Mealy in RUN: they react to this cycle's branch/hazard.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        md_busy     = 1'b0;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        if (rst) begin
            // Hold the front end and inject NOPs until reset is released.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (w_busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            md_busy     = 1'b1;
            w_stall_inc = 1'b1;
        end else if (ex_branch_taken) begin
            // Redirect fetch and kill both younger instructions.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            w_flush_inc = 1'b1;
        end else if (w_load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            w_stall_inc = 1'b1;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_stall_inc),
        .count(stall_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_flush_inc),
        .count(flush_cnt)
    );

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MD_LAT, default 4: total EX-occupancy cycles of a multiply/divide instruction; legal range 2..15.
REQ-002 Parameter CNT_W, default 16: width of the saturating performance counters.
REQ-003 Ports, in this order:
  clk  in  1  clock; all state updates on its rising edge.
  rst  in  1  reset, asynchronous, active-high.
  id_rs  in  5  Rs field of the instruction in ID.
  id_rt  in  5  Rt field of the instruction in ID.
  id_uses_rs  in  1  ID instruction reads Rs.
  id_uses_rt  in  1  ID instruction reads Rt.
  id_md_start  in  1  ID instruction is a multiply/divide.
  ex_mem_read  in  1  ID/EX register holds a load.
  ex_rt  in  5  destination register of the instruction in ID/EX.
  ex_branch_taken  in  1  branch resolved taken in EX this cycle.
  pc_write  out  1  PC update enable.
  ifid_write  out  1  IF/ID load enable.
  ifid_flush  out  1  clear IF/ID to NOP.
  idex_bubble  out  1  zero the EX/M/WB control fields entering ID/EX.
  md_busy  out  1  multiply/divide unit occupied.
  stall_cnt  out  CNT_W  count of stall cycles.
  flush_cnt  out  CNT_W  count of taken-branch flushes.

Function
REQ-004 The FSM SHALL have exactly two states: RUN and MD_BUSY.
REQ-005 A load-use hazard (LU) SHALL exist when ex_mem_read=1, ex_rt!=0, and either (id_uses_rs and id_rs==ex_rt) or (id_uses_rt and id_rt==ex_rt).
REQ-006 In RUN, same-cycle (Mealy) priority: ex_branch_taken, then LU, then id_md_start, then normal flow.
REQ-007 RUN with ex_branch_taken=1: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1; flush_cnt increments; LU and id_md_start are ignored that cycle.
REQ-008 RUN with LU and no branch: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1; stall_cnt increments; id_md_start is not accepted that cycle.
REQ-009 RUN with id_md_start and no branch and no LU: normal flow that cycle; at the next edge go to MD_BUSY with down-counter=MD_LAT-2.
REQ-010 In MD_BUSY: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1, md_busy=1; stall_cnt increments every cycle; ex_branch_taken and LU are ignored.
REQ-011 MD_BUSY with down-counter==0 SHALL go to RUN at the next edge; otherwise the counter decrements. Net effect: exactly MD_LAT-1 stall cycles per multiply/divide.
REQ-012 Normal flow SHALL be: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, md_busy=0.
REQ-013 stall_cnt and flush_cnt SHALL saturate at all-ones and never wrap.

Reset
REQ-014 While rst=1: state=RUN, down-counter=0, stall_cnt=0, flush_cnt=0, pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, md_busy=0.
REQ-015 Asserting rst during MD_BUSY SHALL abort the operation immediately; after rst deasserts, the first cycle is RUN with no residual stall.

Configuration
REQ-016 Macro HAZARD_MULDIV_EN defined: REQ-009..REQ-011 are implemented as written.
REQ-017 Macro HAZARD_MULDIV_EN undefined:
  - id_md_start is ignored;
  - md_busy is tied to 0;
  - the MD_BUSY state and its down-counter are not built;
  - all ports remain present.

Structure
REQ-018 Package hazard_pkg SHALL hold the FSM state enum (RUN, MD_BUSY) and the constant REG_ZERO=5'd0.
REQ-019 The saturating counter SHALL be a sub-module sat_counter, instantiated twice.

Verification
REQ-020 Load-use: ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1 -> that cycle pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt 0->1.
REQ-021 Zero register: ex_mem_read=1, ex_rt=0, id_rt=0, id_uses_rt=1 -> no stall; normal flow.
REQ-022 Simultaneous events: ex_branch_taken=1 with the LU of REQ-020 -> ifid_flush=1, pc_write=1, idex_bubble=1; flush_cnt=1; stall_cnt unchanged.
REQ-023 Multiply/divide latency: MD_LAT=4, id_md_start pulsed at cycle T -> md_busy=1 and pc_write=0 at T+1..T+3; RUN at T+4; stall_cnt=3.
REQ-024 Reset mid-operation: rst asserted at T+2 of REQ-023 -> immediately md_busy=0 and counters=0; after release, normal flow.
REQ-025 Saturation and macro-off:
  - CNT_W=4 with 20 consecutive LU cycles -> stall_cnt holds 15.
  - With HAZARD_MULDIV_EN undefined, the REQ-023 stimulus -> no stall.
